// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants, FSM encodings and helper functions
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  typedef enum logic [2:0] {
    TXS_IDLE,
    TXS_START,
    TXS_DATA,
    TXS_PARITY,
    TXS_STOP
  } tx_state_t;

  typedef enum logic [2:0] {
    RXS_IDLE,
    RXS_START,
    RXS_DATA,
    RXS_PARITY,
    RXS_STOP,
    RXS_WAIT_IDLE
  } rx_state_t;

  // Rounded clocks-per-tick divider.
  function automatic int baud_div(input int clk_hz, input int baud, input int os);
    return (clk_hz + (baud * os) / 2) / (baud * os);
  endfunction

  // Parity bit for a payload zero-extended to 9 bits (zeros do not change the XOR).
  function automatic logic parity_bit(input logic [8:0] d, input int mode);
    return (^d) ^ (mode == PAR_ODD);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// rtl/uart_baud_tick.sv - free-running divider producing a one-cycle oversample tick
module uart_baud_tick #(
  parameter int DIV = 27
) (
  input  logic CLK,
  input  logic RST_N,
  output logic TICK
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + W'(1);
    end
  end

  assign TICK = (cnt == LAST);

endmodule

// File: rtl/uart_txrx.sv
// rtl/uart_txrx.sv - full-duplex UART with parity/framing checks and a wrapping TX frame counter
module uart_txrx
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int BAUD       = 115200,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int CNT_W      = 8
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic [DATA_BITS-1:0] TX_DATA,
  input  logic                 TX_START,
  output logic                 TX_BUSY,
  output logic                 TX_PIN,
  input  logic                 RX_PIN,
  output logic [DATA_BITS-1:0] RX_DATA,
  output logic                 RX_VALID,
  output logic                 RX_PARITY_ERR,
  output logic                 RX_FRAME_ERR,
  output logic [CNT_W-1:0]     TX_COUNT
);

  localparam int DIV  = baud_div(CLK_HZ, BAUD, OVERSAMPLE);
  localparam int OS_W = $clog2(OVERSAMPLE);
  localparam logic [OS_W-1:0] OS_LAST   = OS_W'(OVERSAMPLE - 1);
  localparam logic [OS_W-1:0] OS_HALF   = OS_W'(OVERSAMPLE / 2 - 1);
  localparam logic [3:0]      DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]      STOP_LAST = 4'(STOP_BITS - 1);

  logic tick;

  uart_baud_tick #(.DIV(DIV)) u_tick (
    .CLK  (CLK),
    .RST_N(RST_N),
    .TICK (tick)
  );

  // ---------------- transmitter ----------------
  tx_state_t              tx_state, tx_state_n;
  logic                   tx_pin, tx_pin_n;
  logic                   tx_busy, tx_busy_n;
  logic                   tx_par, tx_par_n;
  logic [DATA_BITS-1:0]   tx_sh, tx_sh_n;
  logic [OS_W-1:0]        tx_os, tx_os_n;
  logic [3:0]             tx_bc, tx_bc_n;
  logic [CNT_W-1:0]       tx_cnt, tx_cnt_n;
  logic                   tx_bit_end;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      tx_state <= TXS_IDLE;
      tx_pin   <= 1'b1;
      tx_busy  <= 1'b0;
      tx_par   <= 1'b0;
      tx_sh    <= '0;
      tx_os    <= '0;
      tx_bc    <= '0;
      tx_cnt   <= '0;
    end else begin
      tx_state <= tx_state_n;
      tx_pin   <= tx_pin_n;
      tx_busy  <= tx_busy_n;
      tx_par   <= tx_par_n;
      tx_sh    <= tx_sh_n;
      tx_os    <= tx_os_n;
      tx_bc    <= tx_bc_n;
      tx_cnt   <= tx_cnt_n;
    end
  end

  always_comb begin
    tx_state_n = tx_state;
    tx_pin_n   = tx_pin;
    tx_busy_n  = tx_busy;
    tx_par_n   = tx_par;
    tx_sh_n    = tx_sh;
    tx_os_n    = tx_os;
    tx_bc_n    = tx_bc;
    tx_cnt_n   = tx_cnt;
    tx_bit_end = tick && (tx_os == OS_LAST);
    if (tx_state != TXS_IDLE && tick) begin
      tx_os_n = tx_bit_end ? '0 : tx_os + OS_W'(1);
    end
    case (tx_state)
      TXS_IDLE: begin
        if (TX_START) begin
          tx_state_n = TXS_START;
          tx_sh_n    = TX_DATA;
          tx_par_n   = parity_bit(9'(TX_DATA), PARITY);
          tx_pin_n   = 1'b0;
          tx_busy_n  = 1'b1;
          tx_os_n    = '0;
          tx_cnt_n   = tx_cnt + CNT_W'(1);
        end
      end
      TXS_START: begin
        if (tx_bit_end) begin
          tx_state_n = TXS_DATA;
          tx_pin_n   = tx_sh[0];
          tx_bc_n    = '0;
        end
      end
      TXS_DATA: begin
        if (tx_bit_end) begin
          if (tx_bc == DATA_LAST) begin
            if (PARITY != PAR_NONE) begin
              tx_state_n = TXS_PARITY;
              tx_pin_n   = tx_par;
            end else begin
              tx_state_n = TXS_STOP;
              tx_pin_n   = 1'b1;
              tx_bc_n    = '0;
            end
          end else begin
            tx_sh_n  = tx_sh >> 1;
            tx_pin_n = tx_sh[1];
            tx_bc_n  = tx_bc + 4'd1;
          end
        end
      end
      TXS_PARITY: begin
        if (tx_bit_end) begin
          tx_state_n = TXS_STOP;
          tx_pin_n   = 1'b1;
          tx_bc_n    = '0;
        end
      end
      TXS_STOP: begin
        if (tx_bit_end) begin
          if (tx_bc == STOP_LAST) begin
            tx_state_n = TXS_IDLE;
            tx_busy_n  = 1'b0;
          end else begin
            tx_bc_n = tx_bc + 4'd1;
          end
        end
      end
      default: tx_state_n = TXS_IDLE;
    endcase
  end

  assign TX_PIN   = tx_pin;
  assign TX_BUSY  = tx_busy;
  assign TX_COUNT = tx_cnt;

  // ---------------- receiver ----------------
  logic                 rx_s1, rx_s2;
  rx_state_t            rx_state, rx_state_n;
  logic [OS_W-1:0]      rx_os, rx_os_n;
  logic [3:0]           rx_bc, rx_bc_n;
  logic [DATA_BITS-1:0] rx_sh, rx_sh_n;
  logic                 rx_perr_w, rx_perr_w_n;
  logic                 rx_ferr_w, rx_ferr_w_n;
  logic [DATA_BITS-1:0] rx_data, rx_data_n;
  logic                 rx_valid, rx_valid_n;
  logic                 rx_perr, rx_perr_n;
  logic                 rx_ferr, rx_ferr_n;
  logic                 rx_sample;
  logic                 rx_ferr_now;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rx_s1     <= 1'b1;
      rx_s2     <= 1'b1;
      rx_state  <= RXS_IDLE;
      rx_os     <= '0;
      rx_bc     <= '0;
      rx_sh     <= '0;
      rx_perr_w <= 1'b0;
      rx_ferr_w <= 1'b0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      rx_perr   <= 1'b0;
      rx_ferr   <= 1'b0;
    end else begin
      rx_s1     <= RX_PIN;
      rx_s2     <= rx_s1;
      rx_state  <= rx_state_n;
      rx_os     <= rx_os_n;
      rx_bc     <= rx_bc_n;
      rx_sh     <= rx_sh_n;
      rx_perr_w <= rx_perr_w_n;
      rx_ferr_w <= rx_ferr_w_n;
      rx_data   <= rx_data_n;
      rx_valid  <= rx_valid_n;
      rx_perr   <= rx_perr_n;
      rx_ferr   <= rx_ferr_n;
    end
  end

  always_comb begin
    rx_state_n  = rx_state;
    rx_os_n     = rx_os;
    rx_bc_n     = rx_bc;
    rx_sh_n     = rx_sh;
    rx_perr_w_n = rx_perr_w;
    rx_ferr_w_n = rx_ferr_w;
    rx_data_n   = rx_data;
    rx_valid_n  = 1'b0;
    rx_perr_n   = rx_perr;
    rx_ferr_n   = rx_ferr;
    rx_ferr_now = 1'b0;
    rx_sample   = tick && (rx_os == OS_LAST);
    if (rx_state != RXS_IDLE && rx_state != RXS_WAIT_IDLE && tick) begin
      rx_os_n = rx_sample ? '0 : rx_os + OS_W'(1);
    end
    case (rx_state)
      RXS_IDLE: begin
        if (!rx_s2) begin
          rx_state_n  = RXS_START;
          rx_os_n     = '0;
          rx_perr_w_n = 1'b0;
          rx_ferr_w_n = 1'b0;
        end
      end
      RXS_START: begin
        // Half-bit re-check rejects short glitches and aligns later samples to bit centres.
        if (tick && rx_os == OS_HALF) begin
          if (rx_s2) begin
            rx_state_n = RXS_IDLE;
          end else begin
            rx_state_n = RXS_DATA;
            rx_os_n    = '0;
            rx_bc_n    = '0;
          end
        end
      end
      RXS_DATA: begin
        if (rx_sample) begin
          rx_sh_n = {rx_s2, rx_sh[DATA_BITS-1:1]};
          if (rx_bc == DATA_LAST) begin
            rx_state_n = (PARITY != PAR_NONE) ? RXS_PARITY : RXS_STOP;
            rx_bc_n    = '0;
          end else begin
            rx_bc_n = rx_bc + 4'd1;
          end
        end
      end
      RXS_PARITY: begin
        if (rx_sample) begin
          rx_perr_w_n = (rx_s2 != parity_bit(9'(rx_sh), PARITY));
          rx_state_n  = RXS_STOP;
          rx_bc_n     = '0;
        end
      end
      RXS_STOP: begin
        if (rx_sample) begin
          rx_ferr_now = rx_ferr_w | ~rx_s2;
          rx_ferr_w_n = rx_ferr_now;
          if (rx_bc == STOP_LAST) begin
            rx_data_n  = rx_sh;
            rx_perr_n  = rx_perr_w;
            rx_ferr_n  = rx_ferr_now;
            rx_valid_n = 1'b1;
            rx_state_n = (rx_ferr_now && !rx_s2) ? RXS_WAIT_IDLE : RXS_IDLE;
          end else begin
            rx_bc_n = rx_bc + 4'd1;
          end
        end
      end
      RXS_WAIT_IDLE: begin
        if (rx_s2) begin
          rx_state_n = RXS_IDLE;
        end
      end
      default: rx_state_n = RXS_IDLE;
    endcase
  end

  assign RX_DATA       = rx_data;
  assign RX_VALID      = rx_valid;
  assign RX_PARITY_ERR = rx_perr;
  assign RX_FRAME_ERR  = rx_ferr;

endmodule

// File: tb/tb_uart_txrx.sv
// tb/tb_uart_txrx.sv - directed self-checking bench for uart_txrx
module tb_uart_txrx;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // dut0: default parameters (DIV = 27, 432 clocks per bit), RX driven by bench
  logic [7:0] tx_data0 = 8'h00;
  logic       tx_start0 = 1'b0, rx0 = 1'b1;
  logic       busy0, tx0, v0, perr0, ferr0;
  logic [7:0] d0, count0;

  // dut1: fast even-parity two-stop-bit loopback (DIV = 2, 16 clocks per bit)
  logic [7:0] tx_data1 = 8'h00;
  logic       tx_start1 = 1'b0;
  logic       busy1, tx1, v1, perr1, ferr1;
  logic [7:0] d1, count1;

  // dut2: fast odd-parity one-stop-bit receiver driven by bench
  logic [7:0] tx_data2 = 8'h00;
  logic       tx_start2 = 1'b0, rx2 = 1'b1;
  logic       busy2, tx2, v2, perr2, ferr2;
  logic [7:0] d2, count2;

  // dut3: fast 5-bit no-parity transmitter for counter wrap
  logic [4:0] tx_data3 = 5'h15;
  logic       tx_start3 = 1'b0;
  logic       busy3, tx3, v3, perr3, ferr3;
  logic [4:0] d3;
  logic [7:0] count3;

  uart_txrx dut0 (
    .CLK(clk), .RST_N(rst_n), .TX_DATA(tx_data0), .TX_START(tx_start0),
    .TX_BUSY(busy0), .TX_PIN(tx0), .RX_PIN(rx0), .RX_DATA(d0), .RX_VALID(v0),
    .RX_PARITY_ERR(perr0), .RX_FRAME_ERR(ferr0), .TX_COUNT(count0)
  );

  uart_txrx #(.CLK_HZ(1_000_000), .BAUD(62_500), .OVERSAMPLE(8), .PARITY(2), .STOP_BITS(2)) dut1 (
    .CLK(clk), .RST_N(rst_n), .TX_DATA(tx_data1), .TX_START(tx_start1),
    .TX_BUSY(busy1), .TX_PIN(tx1), .RX_PIN(tx1), .RX_DATA(d1), .RX_VALID(v1),
    .RX_PARITY_ERR(perr1), .RX_FRAME_ERR(ferr1), .TX_COUNT(count1)
  );

  uart_txrx #(.CLK_HZ(1_000_000), .BAUD(62_500), .OVERSAMPLE(8), .PARITY(1), .STOP_BITS(1)) dut2 (
    .CLK(clk), .RST_N(rst_n), .TX_DATA(tx_data2), .TX_START(tx_start2),
    .TX_BUSY(busy2), .TX_PIN(tx2), .RX_PIN(rx2), .RX_DATA(d2), .RX_VALID(v2),
    .RX_PARITY_ERR(perr2), .RX_FRAME_ERR(ferr2), .TX_COUNT(count2)
  );

  uart_txrx #(.CLK_HZ(1_000_000), .BAUD(62_500), .OVERSAMPLE(8), .DATA_BITS(5)) dut3 (
    .CLK(clk), .RST_N(rst_n), .TX_DATA(tx_data3), .TX_START(tx_start3),
    .TX_BUSY(busy3), .TX_PIN(tx3), .RX_PIN(tx3), .RX_DATA(d3), .RX_VALID(v3),
    .RX_PARITY_ERR(perr3), .RX_FRAME_ERR(ferr3), .TX_COUNT(count3)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // RX_VALID capture per receiver
  int v0_cnt = 0, v1_cnt = 0, v2_cnt = 0;
  logic [7:0] v0_data = 8'h00, v1_data = 8'h00, v2_data = 8'h00;
  logic v0_perr = 1'b0, v0_ferr = 1'b0, v1_perr = 1'b0, v1_ferr = 1'b0, v2_perr = 1'b0, v2_ferr = 1'b0;

  always @(negedge clk) begin
    if (v0) begin v0_cnt <= v0_cnt + 1; v0_data <= d0; v0_perr <= perr0; v0_ferr <= ferr0; end
    if (v1) begin v1_cnt <= v1_cnt + 1; v1_data <= d1; v1_perr <= perr1; v1_ferr <= ferr1; end
    if (v2) begin v2_cnt <= v2_cnt + 1; v2_data <= d2; v2_perr <= perr2; v2_ferr <= ferr2; end
  end

  // dut3 accept counting and idle-gap measurement between back-to-back frames
  logic busy3_q = 1'b0;
  int rise3 = 0, low_run3 = 0, gap_max3 = 0;

  always @(negedge clk) begin
    busy3_q <= busy3;
    if (busy3 && !busy3_q) rise3 <= rise3 + 1;
    if (!busy3) begin
      low_run3 <= low_run3 + 1;
    end else begin
      if (rise3 > 0 && low_run3 > gap_max3) gap_max3 <= low_run3;
      low_run3 <= 0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_range(input string tag, input int obs, input int lo, input int hi);
    n_cmp++;
    assert (obs >= lo && obs <= hi) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_frame(input int sel, input logic [15:0] bits, input int nbits, input int blen);
    for (int i = 0; i < nbits; i++) begin
      if (sel == 0) rx0 = bits[i];
      else rx2 = bits[i];
      tick(blen);
    end
  endtask

  initial begin
    int c;
    int k;
    int base;
    logic [9:0] exp_a5;

    // reset state
    tick(3);
    check("rst_tx_pin", tx0, 1'b1);
    check("rst_tx_busy", busy0, 1'b0);
    check("rst_tx_count", count0, 8'd0);
    check("rst_rx_data", d0, 8'h00);
    check("rst_rx_valid", v0, 1'b0);
    check("rst_rx_perr", perr0, 1'b0);
    check("rst_rx_ferr", ferr0, 1'b0);
    check("rst_rx2_data", d2, 8'h00);
    rst_n = 1'b1;
    tick(2);

    // default-rate TX of 8'hA5: bit-centre samples and busy length
    exp_a5 = {1'b1, 8'hA5, 1'b0};
    tx_data0 = 8'hA5;
    tx_start0 = 1'b1;
    tick(1);
    tx_start0 = 1'b0;
    tx_data0 = 8'hFF;
    check("tx0_busy_rise", busy0, 1'b1);
    check("tx0_count_1", count0, 8'd1);
    c = 0;
    k = 0;
    while (busy0 === 1'b1 && c < 5000) begin
      if (k < 10 && c == 200 + 432 * k) begin
        check($sformatf("tx0_bit%0d", k), tx0, exp_a5[k]);
        k++;
      end
      tick(1);
      c++;
    end
    check("tx0_bits_sampled", k, 10);
    check_range("tx0_busy_len", c, 4320 - 26, 4320);
    check("tx0_idle_pin", tx0, 1'b1);

    // loopback: even parity, two stop bits, 8'h3C
    base = v1_cnt;
    tx_data1 = 8'h3C;
    tx_start1 = 1'b1;
    tick(1);
    tx_start1 = 1'b0;
    tick(400);
    check("lb_valid_count", v1_cnt - base, 1);
    check("lb_data", v1_data, 8'h3C);
    check("lb_perr", v1_perr, 1'b0);
    check("lb_ferr", v1_ferr, 1'b0);
    check("lb_tx_count", count1, 8'd1);

    // odd parity expected 1 for 8'h55, drive 0
    base = v2_cnt;
    drive_frame(2, {5'b0, 1'b1, 1'b0, 8'h55, 1'b0}, 11, 16);
    rx2 = 1'b1;
    tick(20);
    check("perr_valid_count", v2_cnt - base, 1);
    check("perr_data", v2_data, 8'h55);
    check("perr_flag", v2_perr, 1'b1);
    check("perr_ferr", v2_ferr, 1'b0);

    // low stop bit followed by a 3-frame break, then a good 8'h81
    base = v2_cnt;
    drive_frame(2, {5'b0, 1'b0, 1'b1, 8'hF0, 1'b0}, 11, 16);
    tick(528);
    check("brk_valid_count", v2_cnt - base, 1);
    check("brk_ferr", v2_ferr, 1'b1);
    check("brk_perr", v2_perr, 1'b0);
    check("brk_data", v2_data, 8'hF0);
    rx2 = 1'b1;
    tick(32);
    check("brk_no_extra", v2_cnt - base, 1);
    drive_frame(2, {5'b0, 1'b1, 1'b1, 8'h81, 1'b0}, 11, 16);
    rx2 = 1'b1;
    tick(20);
    check("post_brk_count", v2_cnt - base, 2);
    check("post_brk_data", v2_data, 8'h81);
    check("post_brk_perr", v2_perr, 1'b0);
    check("post_brk_ferr", v2_ferr, 1'b0);

    // 100-clock glitch at default rate, then a clean 8'h5A
    base = v0_cnt;
    rx0 = 1'b0;
    tick(100);
    rx0 = 1'b1;
    tick(1000);
    check("glitch_no_valid", v0_cnt - base, 0);
    drive_frame(0, {6'b0, 1'b1, 8'h5A, 1'b0}, 10, 432);
    rx0 = 1'b1;
    tick(300);
    check("post_glitch_count", v0_cnt - base, 1);
    check("post_glitch_data", v0_data, 8'h5A);
    check("post_glitch_perr", v0_perr, 1'b0);
    check("post_glitch_ferr", v0_ferr, 1'b0);

    // TX_START held for 300 back-to-back frames
    tx_start3 = 1'b1;
    c = 0;
    while (rise3 < 300 && c < 40000) begin
      tick(1);
      c++;
    end
    tx_start3 = 1'b0;
    check("wrap_reached_300", rise3 >= 300, 1'b1);
    c = 0;
    while (busy3 === 1'b1 && c < 200) begin
      tick(1);
      c++;
    end
    tick(2);
    check("wrap_busy_low", busy3, 1'b0);
    check("wrap_accepts", rise3, 300);
    check("wrap_count", count3, 8'd44);
    check("wrap_idle_gap", gap_max3, 1);

    // reset in the middle of data bit 1 (value 0) of 8'hA5
    tx_data0 = 8'hA5;
    tx_start0 = 1'b1;
    tick(1);
    tx_start0 = 1'b0;
    check("rst2_count_2", count0, 8'd2);
    tick(1000);
    check("rst2_pin_before", tx0, 1'b0);
    rst_n = 1'b0;
    #1;
    check("rst2_pin_now", tx0, 1'b1);
    check("rst2_busy_now", busy0, 1'b0);
    check("rst2_count_now", count0, 8'd0);
    tick(3);
    rst_n = 1'b1;
    tick(2);
    tx_data0 = 8'h0F;
    tx_start0 = 1'b1;
    tick(1);
    tx_start0 = 1'b0;
    check("rst2_reaccept_busy", busy0, 1'b1);
    check("rst2_reaccept_pin", tx0, 1'b0);
    check("rst2_reaccept_count", count0, 8'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
